// File: rtl/mdr_mem_ctrl.sv
// mdr_mem_ctrl: sequences MDR-path data-memory loads and stores.
// Drives the memory strobes, address and write data. Selects the memory bus
// into MDR for exactly one cycle per successful load. Uses a ready handshake
// to absorb variable memory latency and reports a timeout as an error.
module mdr_mem_ctrl #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_load,
   input  logic              req_store,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wdata_in,
   input  logic              dmem_ready,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic              dmem_read,
   output logic              dmem_write,
   output logic              mdr_sel,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_RD_CAP,
      ST_WR_WAIT,
      ST_DONE,
      ST_ERR
   } state_t;

   // Last wait-cycle count before a timeout; the counter starts at 0 on entry.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   state_t      next_state;
   logic [7:0]  wait_cnt;
   logic [7:0]  wait_cnt_next;
   logic        latch_addr;
   logic        latch_wdata;

   // State and wait-counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         wait_cnt <= 8'd0;
      end else begin
         state    <= next_state;
         wait_cnt <= wait_cnt_next;
      end
   end

   // Next-state logic: requests only matter in IDLE, ready only in the wait states
   always_comb begin
      next_state    = state;
      wait_cnt_next = wait_cnt;
      latch_addr    = 1'b0;
      latch_wdata   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_load && req_store) begin
               next_state = ST_ERR;
            end else if (req_load) begin
               next_state    = ST_RD_WAIT;
               wait_cnt_next = 8'd0;
               latch_addr    = 1'b1;
            end else if (req_store) begin
               next_state    = ST_WR_WAIT;
               wait_cnt_next = 8'd0;
               latch_addr    = 1'b1;
               latch_wdata   = 1'b1;
            end
         end
         ST_RD_WAIT, ST_WR_WAIT: begin
            if (dmem_ready) begin
               next_state = (state == ST_RD_WAIT) ? ST_RD_CAP : ST_DONE;
            end else if (wait_cnt == TMO_LAST) begin
               next_state = ST_ERR;
            end else begin
               wait_cnt_next = wait_cnt + 8'd1;
            end
         end
         ST_RD_CAP: next_state = ST_DONE;
         ST_DONE:   next_state = ST_IDLE;
         ST_ERR:    next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   // Registered outputs decoded from the state being entered, so they line up with it
   always_ff @(posedge clk) begin
      if (rst) begin
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_read  <= 1'b0;
         dmem_write <= 1'b0;
         mdr_sel    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         if (latch_addr) begin
            dmem_addr <= addr_in;
         end
         if (latch_wdata) begin
            dmem_wdata <= wdata_in;
         end
         dmem_read  <= (next_state == ST_RD_WAIT) || (next_state == ST_RD_CAP);
         dmem_write <= (next_state == ST_WR_WAIT);
         mdr_sel    <= (next_state == ST_RD_CAP);
         busy       <= (next_state != ST_IDLE);
         done       <= (next_state == ST_DONE);
         err        <= (next_state == ST_ERR);
      end
   end

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// tb_mdr_mem_ctrl: scoreboard bench for mdr_mem_ctrl with a small memory and MDR model.
module tb_mdr_mem_ctrl;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 16;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_load = 1'b0;
   logic              req_store = 1'b0;
   logic [ADDR_W-1:0] addr_in = '0;
   logic [DATA_W-1:0] wdata_in = '0;
   logic              dmem_ready = 1'b0;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_read;
   logic              dmem_write;
   logic              mdr_sel;
   logic              busy;
   logic              done;
   logic              err;

   mdr_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req_load(req_load), .req_store(req_store),
      .addr_in(addr_in), .wdata_in(wdata_in), .dmem_ready(dmem_ready),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_read(dmem_read),
      .dmem_write(dmem_write), .mdr_sel(mdr_sel), .busy(busy), .done(done), .err(err)
   );

   // Free-running clock
   always #5 clk = ~clk;

   typedef struct {
      bit          is_err;
      int          busy_n;
      int          rd_n;
      int          wr_n;
      int          sel_n;
      logic [15:0] addr;
      logic [15:0] wdata;
      bit          chk_mdr;
      logic [15:0] mdr;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   // Memory and MDR as seen on the board, plus the bench's own view of memory
   logic [15:0] mem [256];
   logic [15:0] ref_mem [256];
   logic [15:0] mdr_reg = '0;
   logic [15:0] cur_addr = '0;
   logic [15:0] cur_wdata = '0;

   // Board memory commits writes on ready; MDR loads the memory bus when selected
   always @(posedge clk) begin
      if (dmem_write && dmem_ready) mem[dmem_addr[7:0]] <= dmem_wdata;
      if (mdr_sel) mdr_reg <= mem[dmem_addr[7:0]];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: tallies each access's cycles and checks them when done/err shows up
   int busy_c = 0, rd_c = 0, wr_c = 0, sel_c = 0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         busy_c = 0; rd_c = 0; wr_c = 0; sel_c = 0;
      end else begin
         if (dmem_read && dmem_write) checkOutput("strobe_exclusive", 32'd1, 32'd0);
         busy_c += int'(busy);
         rd_c   += int'(dmem_read);
         wr_c   += int'(dmem_write);
         sel_c  += int'(mdr_sel);
         if (done || err) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_completion", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("err_flag", {31'd0, err}, {31'd0, e.is_err});
               checkOutput("done_flag", {31'd0, done}, {31'd0, !e.is_err});
               checkOutput("busy_cycles", busy_c, e.busy_n);
               checkOutput("read_cycles", rd_c, e.rd_n);
               checkOutput("write_cycles", wr_c, e.wr_n);
               checkOutput("sel_cycles", sel_c, e.sel_n);
               checkOutput("dmem_addr", {16'd0, dmem_addr}, {16'd0, e.addr});
               checkOutput("dmem_wdata", {16'd0, dmem_wdata}, {16'd0, e.wdata});
               if (e.chk_mdr) checkOutput("mdr_value", {16'd0, mdr_reg}, {16'd0, e.mdr});
            end
            busy_c = 0; rd_c = 0; wr_c = 0; sel_c = 0;
         end
      end
   end

   task automatic waitIdle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) checkOutput("idle_timeout", 32'd1, 32'd0);
   endtask

   // One transaction: ready comes after 'delay' wait cycles; delay >= TIMEOUT means never
   task automatic applyStimulus(input bit ld, input bit st, input logic [15:0] a,
                                input logic [15:0] d, input int delay, input bit extra_req);
      exp_t e;
      bit   timed_out = (delay >= TIMEOUT);
      waitIdle();
      e = '{is_err: 1'b0, busy_n: 0, rd_n: 0, wr_n: 0, sel_n: 0,
            addr: 16'h0, wdata: 16'h0, chk_mdr: 1'b0, mdr: 16'h0};
      if (ld && st) begin
         e.is_err = 1'b1; e.busy_n = 1;
      end else begin
         cur_addr = a;
         if (st) cur_wdata = d;
         if (timed_out) begin
            e.is_err = 1'b1;
            e.busy_n = TIMEOUT + 1;
            if (ld) e.rd_n = TIMEOUT; else e.wr_n = TIMEOUT;
         end else if (ld) begin
            e.busy_n = delay + 3; e.rd_n = delay + 2; e.sel_n = 1;
            e.chk_mdr = 1'b1; e.mdr = ref_mem[a[7:0]];
         end else begin
            e.busy_n = delay + 2; e.wr_n = delay + 1;
            ref_mem[a[7:0]] = d;
         end
      end
      e.addr  = cur_addr;
      e.wdata = cur_wdata;
      exp_q.push_back(e);

      req_load = ld; req_store = st; addr_in = a; wdata_in = d;
      @(posedge clk); #1;
      req_load = 1'b0; req_store = 1'b0;
      addr_in = 16'($urandom); wdata_in = 16'($urandom);
      if (extra_req) begin
         req_load = 1'b1;
         @(posedge clk); #1;
         req_load = 1'b0;
      end
      if (!(ld && st)) begin
         if (!timed_out) begin
            repeat (delay) @(posedge clk);
            #1 dmem_ready = 1'b1;
            @(posedge clk); #1 dmem_ready = 1'b0;
         end else begin
            repeat (TIMEOUT + 2) @(posedge clk);
            #1 dmem_ready = 1'b1;
            @(posedge clk); #1 dmem_ready = 1'b0;
         end
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_addr"}, {16'd0, dmem_addr}, 32'd0);
      checkOutput({tag, "_wdata"}, {16'd0, dmem_wdata}, 32'd0);
      checkOutput({tag, "_flags"},
                  {26'd0, dmem_read, dmem_write, mdr_sel, busy, done, err}, 32'd0);
   endtask

   // Watchdog so the run always ends
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by a randomized stream
   initial begin
      int kind, dly;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 16'(i * 257) ^ 16'h5A5A;
         ref_mem[i] = 16'(i * 257) ^ 16'h5A5A;
      end
      mem[8'h40]     = 16'hBEEF;
      ref_mem[8'h40] = 16'hBEEF;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkIdleOutputs("reset");

      applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 1'b0);
      applyStimulus(1'b0, 1'b1, 16'h0100, 16'h1234, 3, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0000, 20, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h0200, 16'h5555, 0, 1'b1);
      applyStimulus(1'b1, 1'b0, 16'h0100, 16'h0000, TIMEOUT - 1, 1'b0);

      // Reset in the second read-wait cycle, then a stray ready
      waitIdle();
      req_load = 1'b1; addr_in = 16'h0077;
      @(posedge clk); #1 req_load = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      cur_addr = 16'h0; cur_wdata = 16'h0;
      @(negedge clk);
      checkIdleOutputs("midreset");
      dmem_ready = 1'b1;
      @(posedge clk); #1 dmem_ready = 1'b0;
      repeat (3) @(negedge clk);
      checkIdleOutputs("after_stray_ready");

      for (int t = 0; t < 25; t++) begin
         kind = $urandom_range(0, 9);
         dly  = $urandom_range(0, TIMEOUT + 2);
         if (kind == 0)
            applyStimulus(1'b1, 1'b1, 16'($urandom), 16'($urandom), 0, 1'($urandom));
         else
            applyStimulus(kind < 5, kind >= 5, {8'h00, 8'($urandom)}, 16'($urandom), dly, 1'b0);
      end

      waitIdle();
      repeat (2) @(negedge clk);
      checkOutput("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mdr_mem_ctrl.md
Name: mdr_mem_ctrl

Overview:
- Sequences data-memory accesses for the MDR path.
- Accepts load/store requests from the control unit and drives the memory read/write strobes, address and write data.
- Generates the MDR mux select (memory vs C bus) so MDR captures memory data only in the correct cycle.
- Handles variable memory latency via a ready handshake, with timeout error reporting.

Parameters:
- DATA_W, 16, data bus width (MDR, memory data).
- ADDR_W, 16, memory address width.
- TIMEOUT, 15, max cycles in a wait state without dmem_ready before error; range 1..255.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_load  in  1  control-unit load request; sampled in IDLE only.
- req_store  in  1  control-unit store request; sampled in IDLE only.
- addr_in  in  ADDR_W  access address (from AR); latched with request.
- wdata_in  in  DATA_W  store data (from MDR); latched with request.
- dmem_ready  in  1  memory acknowledge; read data valid / write accepted.
- dmem_addr  out  ADDR_W  registered memory address.
- dmem_wdata  out  DATA_W  registered store data.
- dmem_read  out  1  memory read strobe.
- dmem_write  out  1  memory write strobe.
- mdr_sel  out  1  MDR mux select: 1 = load Mem_Data_Bus, 0 = C bus.
- busy  out  1  access in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse (timeout or conflicting request).

Behaviour:
- All outputs are registered.
- Reset (synchronous, any state, including mid-access):
  - state = IDLE; dmem_addr and dmem_wdata = 0; all 1-bit outputs = 0; wait counter = 0.
  - The effect appears on the cycle after the rst edge.
- States: IDLE, RD_WAIT, RD_CAP, WR_WAIT, DONE, ERR.
- IDLE:
  - busy = 0, all strobes 0.
  - req_load only: latch addr_in -> RD_WAIT.
  - req_store only: latch addr_in and wdata_in -> WR_WAIT.
  - Both high in the same cycle: no access, -> ERR.
- RD_WAIT:
  - dmem_read = 1, busy = 1, mdr_sel = 0.
  - dmem_ready = 1 -> RD_CAP.
  - Otherwise the counter increments; reaching TIMEOUT -> ERR.
- RD_CAP (exactly one cycle):
  - dmem_read = 1 (memory holds data), mdr_sel = 1, busy = 1.
  - MDR captures Mem_Data_Bus at the edge ending this cycle.
  - -> DONE.
- WR_WAIT:
  - dmem_write = 1, busy = 1.
  - dmem_ready = 1 -> DONE.
  - Otherwise the counter increments; reaching TIMEOUT -> ERR.
- DONE (one cycle):
  - done = 1, busy = 1, all strobes 0.
  - -> IDLE.
- ERR (one cycle):
  - err = 1, done = 0, busy = 1, all strobes 0.
  - mdr_sel is never 1 on the error path.
  - -> IDLE.
- Wait counter:
  - 8 bits, cleared on entry to RD_WAIT/WR_WAIT.
  - Timeout fires when the counter equals TIMEOUT-1 and dmem_ready = 0, i.e. after exactly TIMEOUT wait cycles.
  - dmem_ready in the final wait cycle wins over timeout.
- Latency, with the request sampled at edge N:
  - Strobe is high from cycle N+1.
  - Ready in the first wait cycle gives: load RD_CAP at N+2, done at N+3; store done at N+2.
- Back-to-back: a request is accepted on the first IDLE cycle after DONE/ERR. The minimum gap is therefore one IDLE cycle.
- Ignored inputs:
  - Requests outside IDLE are ignored (not queued).
  - dmem_ready outside the wait states is ignored.
- dmem_addr and dmem_wdata hold their latched values until the next accepted request.
- dmem_read and dmem_write are never both 1.

Test Plan:
- Reset, then req_load with addr_in = 0x0040 and dmem_ready high in the first RD_WAIT cycle -> dmem_read = 1 on cycles N+1..N+2; mdr_sel = 1 only at N+2; MDR = 0xBEEF (memory data); done at N+3; busy 1 for N+1..N+3.
- req_store with addr_in = 0x0100, wdata_in = 0x1234, and ready delayed 3 cycles -> dmem_write = 1 for 4 cycles; dmem_addr = 0x0100; dmem_wdata = 0x1234; done one cycle later; mdr_sel never 1.
- req_load with dmem_ready held low, TIMEOUT = 15 -> dmem_read high 15 cycles; err pulses the next cycle; done = 0; mdr_sel = 0 throughout; returns to IDLE.
- req_load and req_store together -> no strobes; err pulse at N+1; busy 1 for one cycle. A second req_load during busy -> ignored.
- rst asserted during the 2nd RD_WAIT cycle -> next cycle all outputs 0, state IDLE. A later dmem_ready pulse causes no mdr_sel or done.
- dmem_ready asserted in the 15th (final) wait cycle -> completes normally (RD_CAP, then done); no err.
